// File: rtl/arc4_prga_encrypt.sv
//------------------------------------------------------------------------------
// Module   : arc4_prga_encrypt
// Brief    : ARC4 keystream generator that encrypts a length-prefixed message
//            from plaintext RAM into ciphertext RAM using a pre-permuted S-box.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arc4_prga_encrypt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    output logic [7:0] ct_addr,
    output logic [7:0] ct_wrdata,
    output logic       ct_wren
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_ADDI  = 3'd2,
        ST_READI = 3'd3,
        ST_READJ = 3'd4,
        ST_WRJ   = 3'd5,
        ST_PAD   = 3'd6,
        ST_XOR   = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] k_q, k_d;
    logic [7:0] len_q, len_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;
    logic [7:0] ptb_q, ptb_d;
    logic [7:0] s_addr_q, s_addr_d;
    logic [7:0] pt_addr_q, pt_addr_d;
    logic [7:0] ct_addr_q, ct_addr_d;
    logic [7:0] s_wrdata_q, s_wrdata_d;
    logic [7:0] ct_wrdata_q, ct_wrdata_d;

    // Addresses and write data are presented in the cycle they are decided,
    // so the one-cycle memory latency lines up with the following state.
    assign s_addr    = s_addr_d;
    assign pt_addr   = pt_addr_d;
    assign ct_addr   = ct_addr_d;
    assign s_wrdata  = s_wrdata_d;
    assign ct_wrdata = ct_wrdata_d;

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        len_d       = len_q;
        si_d        = si_q;
        sj_d        = sj_q;
        ptb_d       = ptb_q;
        s_addr_d    = s_addr_q;
        pt_addr_d   = pt_addr_q;
        ct_addr_d   = ct_addr_q;
        s_wrdata_d  = s_wrdata_q;
        ct_wrdata_d = ct_wrdata_q;
        rdy         = 1'b0;
        s_wren      = 1'b0;
        ct_wren     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    i_d       = 8'd0;
                    j_d       = 8'd0;
                    k_d       = 8'd1;
                    pt_addr_d = 8'd0;
                    state_d   = ST_LEN;
                end
            end
            ST_LEN: begin
                len_d       = pt_rddata;
                ct_addr_d   = 8'd0;
                ct_wrdata_d = pt_rddata;
                ct_wren     = 1'b1;
                state_d     = (pt_rddata == 8'd0) ? ST_IDLE : ST_ADDI;
            end
            ST_ADDI: begin
                i_d       = i_q + 8'd1;
                s_addr_d  = i_q + 8'd1;
                pt_addr_d = k_q;
                state_d   = ST_READI;
            end
            ST_READI: begin
                si_d     = s_rddata;
                ptb_d    = pt_rddata;
                j_d      = j_q + s_rddata;
                s_addr_d = j_q + s_rddata;
                state_d  = ST_READJ;
            end
            ST_READJ: begin
                // When i==j this reads the unswapped S[i], so the swap is a no-op.
                sj_d       = s_rddata;
                s_addr_d   = i_q;
                s_wrdata_d = s_rddata;
                s_wren     = 1'b1;
                state_d    = ST_WRJ;
            end
            ST_WRJ: begin
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
                s_wren     = 1'b1;
                state_d    = ST_PAD;
            end
            ST_PAD: begin
                s_addr_d = si_q + sj_q;
                state_d  = ST_XOR;
            end
            ST_XOR: begin
                ct_addr_d   = k_q;
                ct_wrdata_d = s_rddata ^ ptb_q;
                ct_wren     = 1'b1;
                // Compare before incrementing so a 255-byte message never wraps k.
                if (k_q == len_q) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d     = k_q + 8'd1;
                    state_d = ST_ADDI;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            k_q         <= 8'd1;
            len_q       <= 8'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            ptb_q       <= 8'd0;
            s_addr_q    <= 8'd0;
            pt_addr_q   <= 8'd0;
            ct_addr_q   <= 8'd0;
            s_wrdata_q  <= 8'd0;
            ct_wrdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            len_q       <= len_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            ptb_q       <= ptb_d;
            s_addr_q    <= s_addr_d;
            pt_addr_q   <= pt_addr_d;
            ct_addr_q   <= ct_addr_d;
            s_wrdata_q  <= s_wrdata_d;
            ct_wrdata_q <= ct_wrdata_d;
        end
    end

endmodule

`default_nettype wire
